sum_deserializer: RTL and testbench
===================================

Name: sum_deserializer

Overview:
- Serial-to-parallel collector directly downstream of the bit-serial adder.
- Accepts the adder's LSB-first sum bitstream plus carry-out under a valid/ready handshake.
- Reassembles each stream into a parallel {cout, sum} word and presents it on a second valid/ready interface.
- A shift register plus a one-deep output register let the next word stream in while the previous word waits for its consumer.

Parameters:
- DATA_WIDTH, 16, number of serial sum bits per word (>= 2).
- CNT_WIDTH, 16, width of the optional word counter.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  global enable; when 0, all state holds and no handshake completes.
- i_sum  in  1  serial sum bit from the adder, LSB first.
- i_cout  in  1  adder carry-out; sampled only with the last bit of a word.
- i_valid  in  1  serial bit on i_sum is valid.
- o_ready  out  1  block accepts a serial bit this cycle.
- o_word  out  DATA_WIDTH+1  parallel result {cout, sum[DATA_WIDTH-1:0]}.
- o_valid  out  1  o_word holds a complete word.
- i_ready  in  1  consumer accepts o_word.
- o_word_count  out  CNT_WIDTH  words delivered (SUM_DESER_CNT_EN only; otherwise absent).

Behaviour:
- Reset (async assert, sync release): state = COLLECT, bit index = 0, shift register = 0, o_word = 0, o_valid = 0, o_ready = 0 while i_rst_n is low.
- Serial accept: bit_acc = i_en & i_valid & o_ready. A bit is accepted only on a cycle where bit_acc = 1.
- Output accept: word_acc = i_en & o_valid & i_ready.
- o_ready = (state == COLLECT) & i_rst_n, registered-state based. It has no combinational path from i_valid.
- COLLECT state:
  - On each bit_acc, i_sum is written to shift[idx] and idx is incremented.
  - i_valid low mid-word pauses collection; idx holds and no bits are lost.
- Last bit (bit_acc with idx = DATA_WIDTH-1):
  - i_cout is captured; idx wraps to 0.
  - If the output register is free (o_valid = 0, or word_acc this same cycle), load o_word = {i_cout, shift with final bit} on the next edge, set o_valid = 1, and stay in COLLECT.
  - Otherwise go to FULL.
- FULL state:
  - o_ready = 0; shift register and captured cout hold.
  - On word_acc, move the held word into o_word with o_valid staying 1, then return to COLLECT.
- o_valid clears on word_acc when no new word is loading that cycle.
- o_word is stable while o_valid = 1 and i_ready = 0.
- Latency: o_valid rises on the edge after the last bit is accepted when the output register is free.
- Throughput: one word per DATA_WIDTH cycles, with no bubble when i_ready is held high.
- i_en = 0: everything freezes, including FULL-to-output transfer.
- Reset mid-word: the partial word is discarded and o_valid clears immediately (asynchronous).

Optional Feature:
- Macro: SUM_DESER_CNT_EN.
- Defined:
  - o_word_count increments on every word_acc and saturates at all-ones.
  - Resets to 0.
- Undefined: port and counter logic are omitted entirely.

Test Plan:
- Stream sum 0xA5C3 LSB first with cout = 1, i_ready = 1 -> o_valid pulses for one cycle, o_word = 0x1A5C3, latency 1 cycle after the 16th bit.
- Stream 0x00FF with cout = 0 and i_valid deasserted for 3 cycles after bit 5 -> o_word = 0x000FF, exactly 16 bits consumed.
- i_ready = 0; stream 0x1234/cout 0, then 0xFFFF/cout 1:
  - First word is held on o_word = 0x01234.
  - Second word completes and the block enters FULL with o_ready = 0.
  - Raise i_ready -> 0x01234 then 0x1FFFF delivered in order; o_ready returns to 1.
- Assert i_rst_n low after 7 bits of 0xBEEF -> o_valid = 0, o_word = 0, o_ready = 0 during reset.
  - After release, a fresh stream of 0x0001/cout 0 gives o_word = 0x00001.
- Hold i_en = 0 for 4 cycles mid-word and mid-output-wait -> idx, o_word and o_valid unchanged; the resumed result is correct.
- SUM_DESER_CNT_EN, 100 random words with i_ready toggling randomly:
  - o_word_count = 100.
  - Every o_word equals {cout, sum} of the matching serial stream.

Source files
------------

// File: rtl/sum_deserializer_if.sv
// Handshake bundle for sum_deserializer: serial sum side plus word side.
// master = upstream adder / downstream consumer, slave = deserializer.
interface sum_deserializer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  sum;
    logic                  cout;
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH:0]   word;
    logic                  word_valid;
    logic                  word_ready;

    modport master (
        output sum, cout, valid, word_ready,
        input  ready, word, word_valid
    );

    modport slave (
        input  sum, cout, valid, word_ready,
        output ready, word, word_valid
    );
endinterface

// File: rtl/sum_deserializer.sv
// Collects an LSB-first serial sum plus carry into a {cout, sum} word.
// Optional word counter enabled by defining SUM_DESER_CNT_EN.
module sum_deserializer #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    sum_deserializer_if.slave    bus
`ifdef SUM_DESER_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] o_word_count
`endif
);
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    if (DATA_WIDTH < 2 || CNT_WIDTH < 1) begin : g_bad_param
        $error("sum_deserializer: bad parameter");
    end

    typedef enum logic {
        COLLECT,
        FULL
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  cout_hold;
    logic [DATA_WIDTH:0]   word_q;
    logic                  valid_q;

    logic                  bit_acc;
    logic                  word_acc;
    logic                  last_bit;
    logic                  load_now;
    logic [DATA_WIDTH:0]   done_word;

    assign bus.ready  = (state == COLLECT) & i_rst_n;
    assign bus.word   = word_q;
    assign bus.word_valid = valid_q;

    assign bit_acc   = i_en & bus.valid & bus.ready;
    assign word_acc  = i_en & valid_q & bus.word_ready;
    assign last_bit  = bit_acc & (idx == LAST_IDX);
    assign load_now  = last_bit & (~valid_q | word_acc);
    assign done_word = {bus.cout, bus.sum, shift[DATA_WIDTH-2:0]};

    // Collect bits, hand finished words to the output register or park them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= COLLECT;
            idx       <= '0;
            shift     <= '0;
            cout_hold <= 1'b0;
            word_q    <= '0;
            valid_q   <= 1'b0;
        end else if (i_en) begin
            unique case (state)
                COLLECT: begin
                    if (bit_acc) begin
                        shift[idx] <= bus.sum;
                        idx        <= last_bit ? '0 : idx + 1'b1;
                    end
                    if (load_now) begin
                        word_q  <= done_word;
                        valid_q <= 1'b1;
                    end else if (last_bit) begin
                        cout_hold <= bus.cout;
                        state     <= FULL;
                    end else if (word_acc) begin
                        valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (word_acc) begin
                        word_q <= {cout_hold, shift};
                        state  <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef SUM_DESER_CNT_EN
    // Count delivered words, sticking at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_word_count <= '0;
        end else if (word_acc && (o_word_count != '1)) begin
            o_word_count <= o_word_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_sum_deserializer.sv
// Bench for sum_deserializer: directed scenarios plus random words
// checked against a queue-based model of the serial stream.
module tb_sum_deserializer;
    localparam int W  = 16;
    localparam int CW = 16;

    logic tb_clk = 1'b0;
    logic rst_n;
    logic en;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   delivered = 0;
    int   tot_bits = 0;
    bit   done_rnd;

    logic         bits[$];
    logic [W:0]   exp_q[$];
    logic         prev_hold;
    logic [W:0]   prev_word;

    sum_deserializer_if #(.DATA_WIDTH(W)) bus ();

`ifdef SUM_DESER_CNT_EN
    logic [CW-1:0] word_count;
`endif

    sum_deserializer #(
        .DATA_WIDTH (W),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk        (tb_clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .bus          (bus.slave)
`ifdef SUM_DESER_CNT_EN
        ,
        .o_word_count (word_count)
`endif
    );

    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    // Model: words are rebuilt from the bits the handshake actually moved.
    always @(negedge tb_clk) begin
        logic [W:0] w;
        if (!rst_n) begin
            bits.delete();
            exp_q.delete();
            prev_hold = 1'b0;
            delivered = 0;
        end else begin
            if (prev_hold) chk("hold", 32'(bus.word), 32'(prev_word));
            if (en && bus.valid && bus.ready) begin
                bits.push_back(bus.sum);
                tot_bits++;
                if (bits.size() == W) begin
                    w[W] = bus.cout;
                    for (int k = 0; k < W; k++) w[k] = bits[k];
                    exp_q.push_back(w);
                    bits.delete();
                end
            end
            if (en && bus.word_valid && bus.word_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious", 32'd1, 32'd0);
                end else begin
                    chk("word", 32'(bus.word), 32'(exp_q.pop_front()));
                    delivered++;
                end
            end
            prev_hold = bus.word_valid && !(en && bus.word_ready);
            prev_word = bus.word;
        end
    end

    task automatic send_range(input logic [W-1:0] s, input logic c,
                              input int lo, input int hi,
                              input int gap_at, input int gap_len,
                              input bit rnd);
        bit acc;
        int n;
        for (int i = lo; i <= hi; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                bus.valid = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end
            bus.valid = 1'b1;
            bus.sum   = s[i];
            bus.cout  = (i == W - 1) ? c : 1'($urandom_range(0, 1));
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 200) begin
                @(negedge tb_clk);
                acc = en && bus.valid && bus.ready && rst_n;
                tick();
                n++;
            end
            if (!acc) chk("bit_timeout", 32'd0, 32'd1);
            if (i == gap_at) begin
                bus.valid = 1'b0;
                repeat (gap_len) tick();
            end
        end
        bus.valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] s, input logic c);
        send_range(s, c, 0, W - 1, -1, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        chk("rst_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_word", 32'(bus.word), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int b0;
        rst_n = 1'b0;
        en    = 1'b1;
        bus.sum = 1'b0;
        bus.cout = 1'b0;
        bus.valid = 1'b0;
        bus.word_ready = 1'b0;
        done_rnd = 1'b0;
        #1;
        do_reset();
        chk("post_rst_ready", 32'(bus.ready), 32'd1);

        // Single word, consumer always ready: one-cycle pulse.
        bus.word_ready = 1'b1;
        send_word(16'hA5C3, 1'b1);
        chk("t1_valid", 32'(bus.word_valid), 32'd1);
        chk("t1_word", 32'(bus.word), 32'h1A5C3);
        tick();
        chk("t1_pulse", 32'(bus.word_valid), 32'd0);

        // Valid gap mid-word loses nothing.
        b0 = tot_bits;
        send_range(16'h00FF, 1'b0, 0, W - 1, 5, 3, 1'b0);
        chk("t2_word", 32'(bus.word), 32'h000FF);
        chk("t2_bits", 32'(tot_bits - b0), 32'd16);
        tick();

        // Back-pressure: second word parks in FULL.
        bus.word_ready = 1'b0;
        send_word(16'h1234, 1'b0);
        chk("t3_first", 32'(bus.word), 32'h01234);
        send_word(16'hFFFF, 1'b1);
        tick();
        chk("t3_full_ready", 32'(bus.ready), 32'd0);
        chk("t3_held", 32'(bus.word), 32'h01234);
        bus.word_ready = 1'b1;
        tick();
        chk("t3_second", 32'(bus.word), 32'h1FFFF);
        chk("t3_valid2", 32'(bus.word_valid), 32'd1);
        chk("t3_ready_back", 32'(bus.ready), 32'd1);
        tick();
        chk("t3_drained", 32'(bus.word_valid), 32'd0);

        // Enable low mid-word and while a word waits.
        bus.word_ready = 1'b0;
        send_word(16'h5A5A, 1'b1);
        send_range(16'hC0DE, 1'b0, 0, 7, -1, 0, 1'b0);
        en = 1'b0;
        bus.word_ready = 1'b1;
        bus.valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t5_frz_valid", 32'(bus.word_valid), 32'd1);
            chk("t5_frz_word", 32'(bus.word), 32'h15A5A);
        end
        bus.valid = 1'b0;
        en = 1'b1;
        send_range(16'hC0DE, 1'b0, 8, W - 1, -1, 0, 1'b0);
        chk("t5_resume", 32'(bus.word), 32'h0C0DE);
        tick();

        // Reset mid-word discards the partial stream.
        send_range(16'hBEEF, 1'b1, 0, 6, -1, 0, 1'b0);
        do_reset();
        send_word(16'h0001, 1'b0);
        chk("t4_fresh", 32'(bus.word), 32'h00001);
        tick();

        // Random words with a randomly stalling consumer.
        do_reset();
        fork
            begin
                for (int k = 0; k < 100; k++)
                    send_range(16'($urandom), 1'($urandom_range(0, 1)),
                               0, W - 1, -1, 0, 1'b1);
                done_rnd = 1'b1;
            end
            begin
                while (!done_rnd) begin
                    tick();
                    bus.word_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.word_ready = 1'b1;
        repeat (6) tick();
        chk("rnd_drained", 32'(exp_q.size()), 32'd0);
        chk("rnd_words", 32'(delivered), 32'd100);
`ifdef SUM_DESER_CNT_EN
        chk("rnd_count", 32'(word_count), 32'd100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
